tick_prescaler: RTL and testbench

Clock-enable prescaler that sits directly upstream of the tutorial counters. It divides `clock` by `DIVISOR` and emits a one-cycle `tick` strobe that downstream counters use as their count enable, so they advance at a human-visible rate instead of every clock edge. A small run/stop/single-step state machine lets the bench or board buttons start, stop, or step the downstream count.

---
 rtl/tick_prescaler_pkg.sv | 19 +
 rtl/tick_prescaler_if.sv | 19 +
 rtl/tick_prescaler_mod_counter.sv | 33 +++
 rtl/tick_prescaler.sv | 114 +++++++++++
 tb/tb_tick_prescaler.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/tick_prescaler_pkg.sv
// Shared state encoding and parameter-legality helpers for the tick prescaler.
package tick_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  localparam int unsigned DIVISOR_MIN = 32'd1;

  // Upper bound is 2**cnt_w; widened so cnt_w up to 32 cannot overflow.
  function automatic bit divisor_legal(input int unsigned div, input int unsigned cnt_w);
    longint unsigned max_div;
    max_div = 64'd1 << cnt_w;
    return (div >= DIVISOR_MIN) && (64'(div) <= max_div);
  endfunction

endpackage

// File: rtl/tick_prescaler_if.sv
// Control/status bundle for tick_prescaler; square exists only with TICK_PRESCALER_SQUARE_EN.
interface tick_prescaler_if #(
  parameter int CNT_W = 4
) ();
  logic             run;
  logic             step;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] phase;
`ifdef TICK_PRESCALER_SQUARE_EN
  logic             square;

  modport master (output run, output step, input tick, input busy, input phase, input square);
  modport slave  (input run, input step, output tick, output busy, output phase, output square);
`else
  modport master (output run, output step, input tick, input busy, input phase);
  modport slave  (input run, input step, output tick, output busy, output phase);
`endif
endinterface

// File: rtl/tick_prescaler_mod_counter.sv
// CNT_W-bit modulo-DIVISOR counter with clear (priority), enable and terminal-count flag.
module mod_counter #(
  parameter int DIVISOR = 16,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_count;

  // Wrap compares against DIVISOR-1 so non-power-of-2 divisors work.
  assign o_wrap  = (r_count == LAST);
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_count <= o_wrap ? {CNT_W{1'b0}} : (r_count + CNT_W'(1));
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler with run/stop/single-step control.
// Optional square-wave output enabled by TICK_PRESCALER_SQUARE_EN.
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int DIVISOR = 16,
  parameter int CNT_W   = 4
) (
  input  logic           clock,
  input  logic           reset,
  tick_prescaler_if.slave bus
);

  if (!divisor_legal(DIVISOR, CNT_W)) begin : g_bad_divisor
    $error("tick_prescaler: DIVISOR out of range 1..2**CNT_W");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_clr;
  logic             w_wrap;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] w_count;
  logic             r_tick;
  logic             r_busy;

  mod_counter #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_en    (!w_clr),
    .o_count (w_count),
    .o_wrap  (w_wrap)
  );

  // Stop beats a coincident wrap; a step that sees run goes straight to RUNNING.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        w_clr = 1'b1;
        if (bus.run) begin
          w_state_nxt = ST_RUNNING;
        end else if (bus.step) begin
          w_state_nxt = ST_STEPPING;
        end else begin
          w_state_nxt = ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        if (!bus.run) begin
          w_state_nxt = ST_STOPPED;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = ST_RUNNING;
          w_tick_nxt  = w_wrap;
        end
      end
      ST_STEPPING: begin
        w_tick_nxt = w_wrap;
        if (bus.run) begin
          w_state_nxt = ST_RUNNING;
        end else if (w_wrap) begin
          w_state_nxt = ST_STOPPED;
        end else begin
          w_state_nxt = ST_STEPPING;
        end
      end
      default: begin
        w_state_nxt = ST_STOPPED;
        w_clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_STOPPED;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_busy  <= (w_state_nxt != ST_STOPPED);
    end
  end

  assign bus.tick  = r_tick;
  assign bus.busy  = r_busy;
  assign bus.phase = w_count;

`ifdef TICK_PRESCALER_SQUARE_EN
  logic r_square;

  // Toggles on each registered tick; holds through STOPPED, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_square <= 1'b0;
    end else if (w_tick_nxt) begin
      r_square <= !r_square;
    end else begin
      r_square <= r_square;
    end
  end

  assign bus.square = r_square;
`endif

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench: four prescalers (DIVISOR 16, 5, 1, 10) share run/step/reset
// stimulus and are compared every cycle against a behavioural model.
module tb_tick_prescaler;

  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic clock = 1'b0;
  logic tb_run, tb_step, tb_reset;

  always #5 clock = ~clock;

  tick_prescaler_if #(.CNT_W(4)) if16 ();
  tick_prescaler_if #(.CNT_W(4)) if5  ();
  tick_prescaler_if #(.CNT_W(4)) if1  ();
  tick_prescaler_if #(.CNT_W(4)) if10 ();

  assign if16.run = tb_run;  assign if16.step = tb_step;
  assign if5.run  = tb_run;  assign if5.step  = tb_step;
  assign if1.run  = tb_run;  assign if1.step  = tb_step;
  assign if10.run = tb_run;  assign if10.step = tb_step;

  tick_prescaler #(.DIVISOR(16), .CNT_W(4)) u_d16 (.clock(clock), .reset(tb_reset), .bus(if16));
  tick_prescaler #(.DIVISOR(5),  .CNT_W(4)) u_d5  (.clock(clock), .reset(tb_reset), .bus(if5));
  tick_prescaler #(.DIVISOR(1),  .CNT_W(4)) u_d1  (.clock(clock), .reset(tb_reset), .bus(if1));
  tick_prescaler #(.DIVISOR(10), .CNT_W(4)) u_d10 (.clock(clock), .reset(tb_reset), .bus(if10));

  int divs [4] = '{16, 5, 1, 10};
  int m_mode [4];
  int m_cnt  [4];
  bit m_tick [4];
  bit m_busy [4];
  bit m_sq   [4];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ticks [4];
  int busys [4];
  int ft0   = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour applied at one clock edge.
  function automatic void model_step(input bit r, input bit s, input bit rs);
    for (int i = 0; i < 4; i++) begin
      bit w;
      if (rs) begin
        m_mode[i] = M_STOP; m_cnt[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
      end else begin
        w = (m_cnt[i] == divs[i] - 1);
        case (m_mode[i])
          M_STOP: begin
            m_tick[i] = 0;
            m_mode[i] = r ? M_RUN : (s ? M_STEP : M_STOP);
          end
          M_RUN: begin
            if (!r) begin
              m_mode[i] = M_STOP; m_cnt[i] = 0; m_tick[i] = 0;
            end else begin
              m_cnt[i] = (m_cnt[i] + 1) % divs[i]; m_tick[i] = w;
            end
          end
          default: begin
            m_cnt[i] = (m_cnt[i] + 1) % divs[i]; m_tick[i] = w;
            if (r) m_mode[i] = M_RUN;
            else if (w) m_mode[i] = M_STOP;
          end
        endcase
        if (m_tick[i]) m_sq[i] = !m_sq[i];
      end
      m_busy[i] = (m_mode[i] != M_STOP);
    end
  endfunction

  task automatic get_obs(input int i, output logic [31:0] t, output logic [31:0] b,
                         output logic [31:0] p, output logic [31:0] s);
    s = 32'd0;
    case (i)
      0: begin t = 32'(if16.tick); b = 32'(if16.busy); p = 32'(if16.phase);
`ifdef TICK_PRESCALER_SQUARE_EN
         s = 32'(if16.square);
`endif
         end
      1: begin t = 32'(if5.tick); b = 32'(if5.busy); p = 32'(if5.phase);
`ifdef TICK_PRESCALER_SQUARE_EN
         s = 32'(if5.square);
`endif
         end
      2: begin t = 32'(if1.tick); b = 32'(if1.busy); p = 32'(if1.phase);
`ifdef TICK_PRESCALER_SQUARE_EN
         s = 32'(if1.square);
`endif
         end
      default: begin t = 32'(if10.tick); b = 32'(if10.busy); p = 32'(if10.phase);
`ifdef TICK_PRESCALER_SQUARE_EN
         s = 32'(if10.square);
`endif
         end
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] t, b, p, s;
    for (int i = 0; i < 4; i++) begin
      get_obs(i, t, b, p, s);
      check_eq($sformatf("d%0d.tick", divs[i]),  t, 32'(m_tick[i]));
      check_eq($sformatf("d%0d.busy", divs[i]),  b, 32'(m_busy[i]));
      check_eq($sformatf("d%0d.phase", divs[i]), p, 32'(m_cnt[i]));
`ifdef TICK_PRESCALER_SQUARE_EN
      check_eq($sformatf("d%0d.square", divs[i]), s, 32'(m_sq[i]));
`endif
      if (t === 32'd1) ticks[i]++;
      if (b === 32'd1) busys[i]++;
      if (i == 0 && t === 32'd1 && ft0 < 0) ft0 = cyc;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit rs);
    tb_run = r; tb_step = s; tb_reset = rs;
    @(posedge clock);
    cyc++;
    model_step(r, s, rs);
    @(negedge clock);
    compare_all();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      ticks[i] = 0; busys[i] = 0;
    end
  endtask

  initial begin
    int c;
    int guard;
    bit r;
    tb_run = 1'b0; tb_step = 1'b0; tb_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = M_STOP; m_cnt[i] = 0; m_tick[i] = 0; m_busy[i] = 0; m_sq[i] = 0;
    end
    clear_counts();

    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Free-run latency, then stop exactly on the d16 wrap edge.
    c = cyc + 1;
    ft0 = -1;
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("d16.first_tick_latency", 32'(ft0 - c), 32'd16);
    guard = 0;
    while (if16.phase !== 4'd15 && guard < 40) begin
      cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_eq("d16.reach_phase15", 32'(guard < 40), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("stop_on_wrap.tick",  32'(if16.tick),  32'd0);
    check_eq("stop_on_wrap.phase", 32'(if16.phase), 32'd0);
    check_eq("stop_on_wrap.busy",  32'(if16.busy),  32'd0);

    // Single step.
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0);
    clear_counts();
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 24; k++) cycle(1'b0, 1'b0, 1'b0);
    check_eq("step.d5_ticks",  32'(ticks[1]), 32'd1);
    check_eq("step.d5_busy",   32'(busys[1]), 32'd5);
    check_eq("step.d16_ticks", 32'(ticks[0]), 32'd1);
    check_eq("step.d1_busy",   32'(busys[2]), 32'd1);

    // Second step during STEPPING is ignored.
    clear_counts();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 24; k++) cycle(1'b0, 1'b0, 1'b0);
    check_eq("step2.d5_ticks",  32'(ticks[1]), 32'd1);
    check_eq("step2.d10_ticks", 32'(ticks[3]), 32'd1);

    // run and step together from STOPPED: run wins.
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) cycle(1'b1, 1'b0, 1'b0);
    check_eq("runstep.d1_ticks",  32'(ticks[2]), 32'd30);
    check_eq("runstep.d5_ticks",  32'(ticks[1]), 32'd6);
    check_eq("runstep.d10_ticks", 32'(ticks[3]), 32'd3);
    check_eq("runstep.d16_ticks", 32'(ticks[0]), 32'd1);

    // Reset mid-period.
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("midreset.d16_busy",  32'(if16.busy),  32'd0);
    check_eq("midreset.d10_phase", 32'(if10.phase), 32'd0);

    // Randomized traffic.
    r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15, 0) == 0) r = !r;
      cycle(r, ($urandom_range(7, 0) == 0), ($urandom_range(199, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
